lcd_text_formatter: RTL and testbench

LCD_TEXT_FORMATTER -- requirements
Module: lcd_text_formatter

---
 rtl/lcd_text_formatter.sv | 166 ++++++++++++++++
 tb/tb_lcd_text_formatter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_formatter.sv
// lcd_text_formatter
//
// Converts two unsigned 16-bit values into two 16-character ASCII lines
// for a character LCD driver:
//   first_line  = "A=" + five right-justified decimal digits + 9 spaces
//   second_line = "B=" + five right-justified decimal digits + 9 spaces
// Leading zeros become spaces; the units digit is always shown.
// Character 0 (leftmost) lives in bits [127:120], character 15 in [7:0].
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high; wins over everything, incl. start
//   start        request to format one value pair (honoured in IDLE only)
//   value_a/b    16-bit unsigned inputs, captured on the accepted start edge
//   first_line   128-bit ASCII line 1, held stable between updates
//   second_line  128-bit ASCII line 2, held stable between updates
//   busy         high in CONV_A, FMT_A, CONV_B, FMT_B
//   done         one-cycle pulse in DONE, after both lines are written
//   state_dbg    current FSM state encoding (debug/observation only)
//
// Handshake: start is a single-cycle request sampled only while the FSM is
// in IDLE; while busy=1 or done=1 start is dropped (no queuing). done=1 for
// exactly one cycle marks the point where both lines hold the new values.
//
// Timing with start sampled at edge 0: CONV_A cycles 1-16, FMT_A 17,
// CONV_B 18-33, FMT_B 34, DONE 35, IDLE 36.

module lcd_text_formatter (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [15:0]  value_a,
    input  logic [15:0]  value_b,
    output logic [127:0] first_line,
    output logic [127:0] second_line,
    output logic         busy,
    output logic         done,
    output logic [2:0]   state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CONV_A = 3'd1,
        FMT_A  = 3'd2,
        CONV_B = 3'd3,
        FMT_B  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [127:0] BLANK_LINE = {16{8'h20}};

    state_t      state;
    logic [15:0] cap_b;    // value_b waits here while line 1 is converted
    logic [15:0] bin_sr;   // binary shift register; also holds captured value_a
    logic [19:0] bcd;      // five BCD digits, digit 4 in [19:16]
    logic [3:0]  bit_cnt;  // shifts done in the current conversion
    logic [19:0] bcd_next;

    // Double-dabble step: every digit >= 5 gets +3 before the shift, so the
    // shift produces a correct decimal carry.
    function automatic logic [19:0] add3(input logic [19:0] v);
        logic [19:0] r;
        r = v;
        for (int i = 0; i < 5; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Build one line: tag, '=', five digit characters with leading-zero
    // blanking (units digit never blanked), then nine spaces.
    function automatic logic [127:0] fmt_line(input logic [7:0]  tag,
                                              input logic [19:0] d);
        logic [39:0] chars;
        logic        leading;
        logic [3:0]  nib;
        chars   = '0;
        leading = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            nib = d[4*i +: 4];
            if (leading && (nib == 4'd0) && (i != 0)) begin
                chars[8*i +: 8] = 8'h20;
            end else begin
                chars[8*i +: 8] = 8'h30 + {4'h0, nib};
                leading         = 1'b0;
            end
        end
        return {tag, 8'h3D, chars, {9{8'h20}}};
    endfunction

    always_comb begin
        bcd_next = add3(bcd);
        bcd_next = {bcd_next[18:0], bin_sr[15]};
    end

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            first_line  <= BLANK_LINE;
            second_line <= BLANK_LINE;
            cap_b       <= '0;
            bin_sr      <= '0;
            bcd         <= '0;
            bit_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        bin_sr  <= value_a;
                        cap_b   <= value_b;
                        bcd     <= '0;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= CONV_A;
                    end
                end
                CONV_A: begin
                    bcd     <= bcd_next;
                    bin_sr  <= bin_sr << 1;
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd15) begin
                        state <= FMT_A;
                    end
                end
                FMT_A: begin
                    first_line <= fmt_line(8'h41, bcd);
                    bin_sr     <= cap_b;
                    bcd        <= '0;
                    bit_cnt    <= '0;
                    state      <= CONV_B;
                end
                CONV_B: begin
                    bcd     <= bcd_next;
                    bin_sr  <= bin_sr << 1;
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd15) begin
                        state <= FMT_B;
                    end
                end
                FMT_B: begin
                    second_line <= fmt_line(8'h42, bcd);
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_text_formatter.sv
// Self-checking bench for lcd_text_formatter.
// Drivers push the expected lines plus the expected done cycle into exp_q;
// a monitor on the falling edge pops an entry whenever done is high.
// cyc counts rising edges; at a falling edge, cyc == t0 + k means the
// design is in cycle k of an operation whose start was sampled at edge t0.

module tb_lcd_text_formatter;

    localparam int W = 288;  // {first_line, second_line, done_cycle[31:0]}
    localparam logic [127:0] BLANK = {16{8'h20}};

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [15:0]  value_a;
    logic [15:0]  value_b;
    logic [127:0] first_line;
    logic [127:0] second_line;
    logic         busy;
    logic         done;
    logic [2:0]   state_dbg;

    lcd_text_formatter dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .value_a     (value_a),
        .value_b     (value_b),
        .first_line  (first_line),
        .second_line (second_line),
        .busy        (busy),
        .done        (done),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_e;
    int n_checks = 0;
    int n_pass   = 0;
    int t0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                exp_e = exp_q.pop_front();
                check("first_line", first_line, exp_e[287:160]);
                check("second_line", second_line, exp_e[159:32]);
                check("done_cycle", 128'(cyc), {96'd0, exp_e[31:0]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Called at a falling edge; start is sampled at the next rising edge.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [127:0] f, input logic [127:0] s,
                          output int ts);
        ts      = cyc;
        start   = 1'b1;
        value_a = a;
        value_b = b;
        exp_q.push_back({f, s, 32'(ts + 35)});
        @(negedge clk);
        start   = 1'b0;
        value_a = 16'($urandom_range(0, 65535));
        value_b = 16'($urandom_range(0, 65535));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        value_a = '0;
        value_b = '0;

        // Scenario 1: reset held for two edges
        repeat (2) @(negedge clk);
        check("rst_first_line", first_line, BLANK);
        check("rst_second_line", second_line, BLANK);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_done", {127'd0, done}, 128'd0);
        reset = 1'b0;
        @(negedge clk);

        // Scenario 2: zero and maximum value
        run_op(16'd0, 16'd65535, "A=    0         ", "B=65535         ", t0);
        wait_cyc(t0 + 34);
        check("s2_busy_c34", {127'd0, busy}, 128'd1);
        wait_cyc(t0 + 35);
        check("s2_busy_c35", {127'd0, busy}, 128'd0);
        wait_drain();

        // Scenario 3: line update edges
        run_op(16'd12345, 16'd100, "A=12345         ", "B=  100         ", t0);
        wait_cyc(t0 + 17);
        check("s3_first_held_c17", first_line, "A=    0         ");
        check("s3_busy_c17", {127'd0, busy}, 128'd1);
        wait_cyc(t0 + 18);
        check("s3_first_new_c18", first_line, "A=12345         ");
        check("s3_second_held_c18", second_line, "B=65535         ");
        wait_cyc(t0 + 34);
        check("s3_second_held_c34", second_line, "B=65535         ");
        wait_cyc(t0 + 35);
        check("s3_second_new_c35", second_line, "B=  100         ");
        wait_cyc(t0 + 36);
        check("s3_done_c36", {127'd0, done}, 128'd0);
        wait_drain();

        // Scenario 4: start held high, inputs changing mid-operation
        t0      = cyc;
        start   = 1'b1;
        value_a = 16'd111;
        value_b = 16'd222;
        exp_q.push_back({128'("A=  111         "), 128'("B=  222         "), 32'(t0 + 35)});
        exp_q.push_back({128'("A=31000         "), 128'("B=60001         "), 32'(t0 + 71)});
        @(negedge clk);
        value_a = 16'd999;
        value_b = 16'd888;
        wait_cyc(t0 + 35);           // DONE cycle: start must be ignored here
        value_a = 16'd5555;
        value_b = 16'd4444;
        wait_cyc(t0 + 36);           // IDLE cycle: start accepted here
        check("s4_busy_idle_c36", {127'd0, busy}, 128'd0);
        value_a = 16'd31000;
        value_b = 16'd60001;
        wait_cyc(t0 + 37);
        check("s4_busy_second_op", {127'd0, busy}, 128'd1);
        start   = 1'b0;
        value_a = 16'd7;
        value_b = 16'd9;
        wait_drain();

        // Scenario 5: reset in the middle of an operation
        t0      = cyc;
        start   = 1'b1;
        value_a = 16'd7;
        value_b = 16'd0;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(t0 + 19);
        check("s5_first_before_rst", first_line, "A=    7         ");
        wait_cyc(t0 + 20);
        reset = 1'b1;
        wait_cyc(t0 + 21);
        reset = 1'b0;
        check("s5_first_blank", first_line, BLANK);
        check("s5_second_blank", second_line, BLANK);
        check("s5_busy", {127'd0, busy}, 128'd0);
        wait_cyc(t0 + 60);
        check("s5_busy_after", {127'd0, busy}, 128'd0);
        check("s5_state_idle", {125'd0, state_dbg}, 128'd0);

        // Scenario 6: reset and start on the same edge
        reset   = 1'b1;
        start   = 1'b1;
        value_a = 16'd1234;
        value_b = 16'd4321;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("s6_busy", {127'd0, busy}, 128'd0);
        check("s6_state_idle", {125'd0, state_dbg}, 128'd0);
        check("s6_first_blank", first_line, BLANK);
        repeat (40) @(negedge clk);
        check("s6_busy_after", {127'd0, busy}, 128'd0);
        check("s6_second_blank", second_line, BLANK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
